// File: rtl/sdf_ctrl.sv
// sdf_ctrl: phase/frame sequencer for an N-point radix-2 SDF FFT stage chain.
// Drives every stage's butterfly select and the output frame strobes, and flags framing violations.
module sdf_ctrl #(
    parameter int LOG_N = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             di_en,
    output logic             in_rdy,
    output logic [LOG_N-1:0] sel,
    output logic             do_en,
    output logic             do_first,
    output logic             do_last,
    output logic             busy,
    output logic             err
);
    localparam int N = 1 << LOG_N;

    logic [LOG_N-1:0] r_ph;
    logic             r_cur;
    logic             r_prev;
    logic             r_err;

    logic             w_ph_zero;
    logic             w_ph_max;
    logic             w_adv;
    logic             w_win_o;

    assign w_ph_zero = (r_ph == '0);
    assign w_ph_max  = (r_ph == '1);
    assign w_adv     = r_cur | r_prev | (w_ph_zero & di_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ph   <= '0;
            r_cur  <= 1'b0;
            r_prev <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_adv) begin
                r_ph <= r_ph + LOG_N'(1);
            end
            if (w_ph_zero) begin
                r_cur <= di_en;
            end else if (w_ph_max) begin
                r_prev <= r_cur;
                r_cur  <= 1'b0;
            end
            // Away from phase 0, di_en must track cur exactly: a gap or an off-phase start.
            if (!w_ph_zero && (di_en != r_cur)) begin
                r_err <= 1'b1;
            end
        end
    end

    for (genvar s = 0; s < LOG_N; s++) begin : g_stage
        localparam logic [LOG_N-1:0] OFF = LOG_N'(N - (N >> s));
        logic w_win;
        if (s == 0) begin : g_first
            assign w_win = r_cur;
        end else begin : g_rest
            assign w_win = (r_ph >= OFF) ? r_cur : r_prev;
        end
        // OFF's low LOG_N-s bits are zero, so bit LOG_N-1-s of (ph - OFF) equals that bit of ph.
        assign sel[s] = w_win & r_ph[LOG_N-1-s];
    end

    assign w_win_o  = w_ph_max ? r_cur : r_prev;
    assign do_en    = w_win_o;
    assign do_first = w_win_o & w_ph_max;
    assign do_last  = w_win_o & (r_ph == LOG_N'(N - 2));
    assign in_rdy   = w_ph_zero | r_cur;
    assign busy     = r_cur | r_prev;
    assign err      = r_err;

endmodule

// File: tb/tb_sdf_ctrl.sv
// Bench for sdf_ctrl: directed framing cases plus random bursts, scored against a frame-level model.
module tb_sdf_ctrl;
    localparam int LOG_N = 3;
    localparam int N = 1 << LOG_N;

    typedef struct packed {
        logic [LOG_N-1:0] sel;
        logic             do_en;
        logic             do_first;
        logic             do_last;
        logic             busy;
        logic             err;
        logic             in_rdy;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             di_en;
    logic             in_rdy;
    logic [LOG_N-1:0] sel;
    logic             do_en;
    logic             do_first;
    logic             do_last;
    logic             busy;
    logic             err;

    int   checks = 0;
    int   failures = 0;
    int   t = 0;
    int   mon_cyc = 0;
    int   frames[$];
    bit   m_err = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    sdf_ctrl #(.LOG_N(LOG_N)) dut (
        .clk      (clk),
        .rst      (rst),
        .di_en    (di_en),
        .in_rdy   (in_rdy),
        .sel      (sel),
        .do_en    (do_en),
        .do_first (do_first),
        .do_last  (do_last),
        .busy     (busy),
        .err      (err)
    );

    task automatic chk(input string name, input int cyc, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, want);
        end
    endtask

    // Frame-level view: phase is the distance from the latest frame start while anything is in flight.
    function automatic void model_phase(output int ph, output bit curm);
        int L;
        ph = 0;
        curm = 1'b0;
        if (frames.size() > 0) begin
            L = frames[$];
            if (t < L + 2 * N) ph = (t - L) % N;
            curm = (t >= L + 1) && (t <= L + N - 1);
        end
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        int   ph;
        bit   curm;
        int   f;
        int   j;
        e = '0;
        model_phase(ph, curm);
        foreach (frames[i]) begin
            f = frames[i];
            if (t >= f + 1 && t <= f + 2 * N - 1) e.busy = 1'b1;
            if (t >= f + N - 1 && t <= f + 2 * N - 2) e.do_en = 1'b1;
            if (t == f + N - 1) e.do_first = 1'b1;
            if (t == f + 2 * N - 2) e.do_last = 1'b1;
            for (int s = 0; s < LOG_N; s++) begin
                j = t - f - (N - (N >> s));
                if (j >= 0 && j < N && ((j >> (LOG_N - 1 - s)) & 1) != 0) e.sel[s] = 1'b1;
            end
        end
        e.err = m_err;
        e.in_rdy = (ph == 0) || curm;
        return e;
    endfunction

    function automatic void model_update(input bit r, input bit d);
        int ph;
        bit curm;
        if (r) begin
            frames.delete();
            m_err = 1'b0;
        end else begin
            model_phase(ph, curm);
            if (ph == 0) begin
                if (d) frames.push_back(t);
            end else if (d != curm) begin
                m_err = 1'b1;
            end
        end
    endfunction

    task automatic cyc(input bit r, input bit d);
        @(posedge clk);
        #1;
        rst = r;
        di_en = d;
        while (frames.size() > 0 && frames[0] + 2 * N <= t) void'(frames.pop_front());
        exp_q.push_back(model_exp());
        model_update(r, d);
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    task automatic run_bits(input int n, input logic [31:0] bits);
        for (int i = 0; i < n; i++) cyc(1'b0, bits[i]);
    endtask

    task automatic run_random(input int iters);
        int kind;
        int len;
        int pos;
        for (int it = 0; it < iters; it++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                len = N * $urandom_range(1, 3);
                for (int i = 0; i < len; i++) cyc(1'b0, 1'b1);
            end else if (kind == 6) begin
                len = $urandom_range(1, N + 2);
                for (int i = 0; i < len; i++) cyc(1'b0, 1'b1);
            end else if (kind == 7) begin
                pos = $urandom_range(1, N - 1);
                for (int i = 0; i < N; i++) cyc(1'b0, i != pos);
            end else if (kind == 8) begin
                cyc(1'b1, 1'($urandom_range(0, 1)));
            end else begin
                cyc(1'b0, 1'b1);
            end
            idle($urandom_range(0, 2 * N + 2));
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sel",      mon_cyc, int'(sel),      int'(e.sel));
                chk("do_en",    mon_cyc, int'(do_en),    int'(e.do_en));
                chk("do_first", mon_cyc, int'(do_first), int'(e.do_first));
                chk("do_last",  mon_cyc, int'(do_last),  int'(e.do_last));
                chk("busy",     mon_cyc, int'(busy),     int'(e.busy));
                chk("err",      mon_cyc, int'(err),      int'(e.err));
                chk("in_rdy",   mon_cyc, int'(in_rdy),   int'(e.in_rdy));
                mon_cyc++;
            end
        end
    end

    initial begin : watchdog
        #(10 * 60000);
        $display("FAIL watchdog cycle=%0d limit reached", t);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst = 1'b1;
        di_en = 1'b0;
        repeat (2) @(posedge clk);

        run_bits(8, 32'h0000_00FF);
        idle(20);
        run_bits(16, 32'h0000_FFFF);
        idle(24);
        run_bits(8, 32'h0000_00EF);
        idle(20);
        cyc(1'b1, 1'b0);
        run_bits(11, 32'h0000_04FF);
        idle(20);
        cyc(1'b1, 1'b0);
        run_bits(5, 32'h0000_001F);
        cyc(1'b1, 1'b1);
        run_bits(10, 32'h0000_03FC);
        idle(20);

        run_random(120);
        idle(2 * N + 2);

        repeat (2) @(posedge clk);
        chk("drain", t, exp_q.size(), 0);
        chk("cycles", t, mon_cyc, t);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdf_ctrl.md
# sdf_ctrl

Sequencing controller for the N-point radix-2 SDF FFT pipeline. It drives the mux `select` of every SdfUnit2 stage (stage s has DELAY_DEPTH = N>>(s+1)) and generates the frame-level output strobes. It also checks that the input stream is frame-aligned and contiguous. It holds no datapath: it sits beside the stage chain and is driven by the same input-valid that qualifies `di_re`/`di_im`.

## Interface
- `LOG_N`, default 6: log2 of FFT size; N = 2^LOG_N, number of stages = LOG_N (≥ 2).
- `clk`  in  1  master clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `di_en`  in  1  input sample valid; frames are N consecutive cycles.
- `in_rdy`  out  1  a new frame may start, or a frame is mid-acceptance.
- `sel`  out  LOG_N  `sel[s]` drives `select` of stage s (stage 0 = first, depth N/2).
- `do_en`  out  1  final-stage output valid (bit-reversed order).
- `do_first`  out  1  output index 0 of a frame.
- `do_last`  out  1  output index N-1 of a frame.
- `busy`  out  1  any frame in flight.
- `err`  out  1  sticky protocol error.

## Operation
- Phase counter `ph` is LOG_N bits, mod N. Flags are `cur` (frame starting at the latest ph==0) and `prev` (the frame before it).
- `ph` advances every cycle while `cur|prev|(ph==0 & di_en)`. Otherwise it holds at 0 (idle).
- Edge leaving ph==N-1: `prev<=cur`, `cur<=0`.
- Edge leaving ph==0: `cur<=di_en`. A frame starts only when di_en is high at ph==0.
- Stage offset: `off_s = N - (N>>s)`, so off = 0, N/2, 3N/4, …, N-2. Output offset is N-1.
- Local phase: `p_s = (ph - off_s) mod N`.
- Window: `win_s = (ph >= off_s) ? cur : prev`.
- Select: `sel[s] = win_s & p_s[LOG_N-1-s]`. The first D samples of each 2D block are buffered (0); the next D are butterflied (1).
- Output window: `p_o = (ph-(N-1)) mod N` and `win_o = (ph==N-1) ? cur : prev`.
  - `do_en = win_o`
  - `do_first = win_o & (p_o==0)`
  - `do_last = win_o & (p_o==N-1)`
- `in_rdy = (ph==0) | cur`. `busy = cur | prev`.
- Error `err` is set (cleared only by rst) on either of:
  - `di_en==0` while `cur & ph!=0` (gap inside a frame). Timing continues and that frame's outputs are garbage but still strobed.
  - `di_en==1` while `!cur & ph!=0` (misaligned start). The sample is ignored and no frame is created.
- Back-to-back frames: di_en held high across the ph wrap starts the next frame with no bubble. The two flags cover the overlap, since total latency N-1 < N.
- Gaps between frames must be multiples of N while busy. After full drain (cur=prev=0), any cycle may start a frame.

## Timing
- All outputs are Moore functions of registered `ph`, `cur`, `prev`, `err`. There is no combinational path from di_en.
- `sel[s]` is valid in the same cycle the sample reaches stage s. The stage chain is combinational apart from its delay buffers.
- Latency from input sample 0 to output index 0 is N-1 cycles. Output index k appears at cycle T+N-1+k for a frame starting at T.
- A single frame keeps `busy` high from T+1 through T+2N-1. ph returns to 0 at T+2N.
- Reset values: ph=0, cur=prev=0, sel=0, do_en=do_first=do_last=0, busy=0, err=0, in_rdy=1.
- Reset mid-frame aborts all frames immediately. The next cycle is idle.

## Test plan
- **Single frame, LOG_N=3.** di_en high cycles 0–7 gives:
  - sel[0] high 4–7
  - sel[1] high 6,7,10,11
  - sel[2] high 7,9,11,13
  - do_en 7–14, do_first 7, do_last 14, busy 1–15, err=0
- **Back-to-back, LOG_N=3.** di_en high 0–15: do_en continuous 7–22, do_first at 7 and 15, do_last at 14 and 22, no gap.
- **Gap error.** di_en high 0–3, low at 4, high 5–7: err set at cycle 5 and stays set; do_en still 7–14.
- **Misaligned start.** Frame at 0–7, then di_en pulse at cycle 10: err=1, no extra do_en after cycle 14.
- **Reset mid-frame.** rst at cycle 5 of a frame: from cycle 6, sel=0, do_en=0, busy=0, in_rdy=1. A new frame at cycle 8 gives do_first at 15.
- **LOG_N=6 end-to-end** with the SdfUnit2 chain and impulse input x[0]=1: all 64 outputs are 1 (bit-reversed order), do_en for 64 cycles starting 63 cycles after the first di_en.
